// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the main-memory arbiter (mem_arbiter).
package mem_arb_pkg;

    localparam int unsigned BLK_WORDS_DFLT = 8;
    localparam int unsigned IDX_W          = $clog2(BLK_WORDS_DFLT);

    typedef enum logic [1:0] {
        StIdle,
        StIFill,
        StDFill,
        StDWrite
    } state_e;

    typedef enum logic {
        OwnI,
        OwnD
    } owner_e;

    // Clears the word-index bits plus the byte-within-word bit (16-bit words).
    function automatic logic [31:0] blk_align(input logic [31:0] addr, input int unsigned idx_w);
        return addr & ~((32'd1 << (idx_w + 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Issue/return beat counters for one block fill; cleared whenever the arbiter is idle.
module mem_arb_beat_ctr #(
    parameter int unsigned BLK_WORDS = 8,
    parameter int unsigned IdxW      = $clog2(BLK_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            issue_i,
    input  logic            ret_i,
    output logic [IdxW-1:0] issue_idx_o,
    output logic            issue_done_o,
    output logic [IdxW-1:0] ret_idx_o,
    output logic            ret_last_o,
    output logic            ret_full_o
);

    localparam int unsigned CntW = IdxW + 1;

    logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (clr_i) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (issue_i) issue_cnt_d = issue_cnt_q + CntW'(1);
            if (ret_i)   ret_cnt_d   = ret_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign issue_idx_o  = issue_cnt_q[IdxW-1:0];
    assign issue_done_o = (issue_cnt_q == CntW'(BLK_WORDS));
    assign ret_idx_o    = ret_cnt_q[IdxW-1:0];
    assign ret_last_o   = (ret_cnt_q == CntW'(BLK_WORDS - 1));
    assign ret_full_o   = (ret_cnt_q == CntW'(BLK_WORDS));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache and D-cache miss FSMs (block fills, single writes).
// Define MEM_ARB_RR_EN to alternate grants when both caches request together.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BLK_WORDS = BLK_WORDS_DFLT,
    parameter int unsigned MEM_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_grant,
    output logic                         i_data_vld,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         d_grant,
    output logic                         d_data_vld,
    output logic                         d_done,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_rvld
);

    localparam int unsigned IdxW = $clog2(BLK_WORDS);

    if (MEM_LAT < 1 || (32'd1 << IdxW) != BLK_WORDS) begin : g_param_chk
        $error("mem_arbiter: MEM_LAT must be >= 1 and BLK_WORDS a power of 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IdxW-1:0]   issue_idx, ret_idx;
    logic              issue_done, ret_last, ret_full;
    logic              in_fill, issue, ret_acc, pick_d;

    assign in_fill = (state_q == StIFill) || (state_q == StDFill);
    assign issue   = in_fill && !issue_done;
    // Returns outside a fill (e.g. in flight across a reset) are dropped here.
    assign ret_acc = in_fill && mem_rvld && !ret_full;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner_q, last_owner_d;

    assign pick_d = d_req && (!i_req || (last_owner_q == OwnI));

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == StIdle && (d_req || i_req)) last_owner_d = pick_d ? OwnD : OwnI;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last_owner_q <= OwnI;
        else        last_owner_q <= last_owner_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d = d_wr ? StDWrite : StDFill;
                    addr_d  = d_wr ? d_addr : ADDR_W'(blk_align(32'(d_addr), IdxW));
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d = StIFill;
                    addr_d  = ADDR_W'(blk_align(32'(i_addr), IdxW));
                end
            end
            StIFill, StDFill: if (ret_acc && ret_last) state_d = StIdle;
            StDWrite:         state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_arb_beat_ctr #(
        .BLK_WORDS (BLK_WORDS),
        .IdxW      (IdxW)
    ) u_beat_ctr (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (state_q == StIdle),
        .issue_i      (issue),
        .ret_i        (ret_acc),
        .issue_idx_o  (issue_idx),
        .issue_done_o (issue_done),
        .ret_idx_o    (ret_idx),
        .ret_last_o   (ret_last),
        .ret_full_o   (ret_full)
    );

    always_comb begin
        i_grant    = (state_q == StIFill);
        d_grant    = (state_q == StDFill) || (state_q == StDWrite);
        mem_en     = issue || (state_q == StDWrite);
        mem_wr     = (state_q == StDWrite);
        mem_addr   = '0;
        mem_wdata  = '0;
        if (issue) mem_addr = addr_q | ADDR_W'({issue_idx, 1'b0});
        if (state_q == StDWrite) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        i_data_vld = ret_acc && (state_q == StIFill);
        d_data_vld = ret_acc && (state_q == StDFill);
        i_done     = i_data_vld && ret_last;
        d_done     = (d_data_vld && ret_last) || (state_q == StDWrite);
        fill_data  = ret_acc ? mem_rdata : '0;
        fill_idx   = ret_acc ? ret_idx : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int unsigned MemLat = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, i_data_vld, i_done;
    logic        d_grant, d_data_vld, d_done;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvld;

    logic        pipe_v [MemLat];
    logic [15:0] pipe_d [MemLat];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_grant    (i_grant),
        .i_data_vld (i_data_vld),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_grant    (d_grant),
        .d_data_vld (d_data_vld),
        .d_done     (d_done),
        .fill_data  (fill_data),
        .fill_idx   (fill_idx),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvld   (mem_rvld)
    );

    // Memory returns addr ^ 0xA5A5 exactly MemLat cycles after a read issue; not reset.
    always @(posedge clk) begin
        pipe_v[0] <= mem_en && !mem_wr;
        pipe_d[0] <= mem_addr ^ 16'hA5A5;
        for (int i = 1; i < MemLat; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_rvld  = pipe_v[MemLat-1];
    assign mem_rdata = pipe_d[MemLat-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_i_grant"}, i_grant, 0);
        chk({tag, "_d_grant"}, d_grant, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_vld"}, {i_data_vld, d_data_vld}, 0);
        chk({tag, "_done"}, {i_done, d_done}, 0);
        chk({tag, "_fill_data"}, fill_data, 0);
        chk({tag, "_fill_idx"}, fill_idx, 0);
    endtask

    // Entered in grant cycle G; leaves one cycle after the done pulse.
    task automatic run_fill(input bit is_d, input logic [15:0] base, input int drop_at,
                            input bit drop_other);
        logic [15:0] ea;
        for (int c = 0; c < 12; c++) begin
            chk("own_grant", is_d ? d_grant : i_grant, 1);
            chk("oth_grant", is_d ? i_grant : d_grant, 0);
            if (c < 8) begin
                ea = base + 16'(2 * c);
                chk("issue_en", mem_en, 1);
                chk("issue_wr", mem_wr, 0);
                chk("issue_addr", mem_addr, ea);
            end else begin
                chk("issue_en_off", mem_en, 0);
            end
            if (c >= 4) begin
                ea = base + 16'(2 * (c - 4));
                chk("own_vld", is_d ? d_data_vld : i_data_vld, 1);
                chk("fill_idx", fill_idx, 32'(c - 4));
                chk("fill_data", fill_data, ea ^ 16'hA5A5);
            end else begin
                chk("own_vld_early", is_d ? d_data_vld : i_data_vld, 0);
            end
            chk("oth_vld", is_d ? i_data_vld : d_data_vld, 0);
            chk("own_done", is_d ? d_done : i_done, c == 11);
            chk("oth_done", is_d ? i_done : d_done, 0);
            if (c == drop_at) begin
                if (is_d || drop_other)  d_req = 1'b0;
                if (!is_d || drop_other) i_req = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MemLat; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        chk_quiet("reset");
        rst_n = 1'b1;
        tick();
        chk_quiet("idle0");

        // I fill from an unaligned address.
        i_req = 1'b1; i_addr = 16'h0046;
        tick();
        run_fill(1'b0, 16'h0040, 11, 1'b0);
        chk_quiet("gap1");

        // Simultaneous requests: D first, I two cycles after d_done.
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        tick();
        run_fill(1'b1, 16'h2000, 11, 1'b0);
        chk("pair_gap_i_grant", i_grant, 0);
        chk("pair_gap_d_grant", d_grant, 0);
        tick();
        run_fill(1'b0, 16'h0100, 11, 1'b0);
        chk_quiet("gap2");

        // Single-word write.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        tick();
        chk("wr_en", mem_en, 1);
        chk("wr_wr", mem_wr, 1);
        chk("wr_addr", mem_addr, 16'h1234);
        chk("wr_wdata", mem_wdata, 16'hBEEF);
        chk("wr_d_grant", d_grant, 1);
        chk("wr_d_done", d_done, 1);
        chk("wr_i_grant", i_grant, 0);
        d_req = 1'b0; d_wr = 1'b0;
        tick();
        chk_quiet("wr_after");

        // Second simultaneous pair, last owner was D.
        i_req = 1'b1; i_addr = 16'h0200;
        d_req = 1'b1; d_addr = 16'h2010;
        tick();
`ifdef MEM_ARB_RR_EN
        run_fill(1'b0, 16'h0200, 11, 1'b1);
`else
        run_fill(1'b1, 16'h2010, 11, 1'b1);
`endif
        chk_quiet("gap3");

        // Top-of-memory blocks stay within the block.
        d_req = 1'b1; d_addr = 16'hFFF8;
        tick();
        run_fill(1'b1, 16'hFFF0, 11, 1'b0);
        chk_quiet("gap4");
        d_req = 1'b1; d_addr = 16'hFFFE;
        tick();
        run_fill(1'b1, 16'hFFF0, 11, 1'b0);
        chk_quiet("gap5");

        // Reset in the middle of an I fill; late returns must be ignored.
        i_req = 1'b1; i_addr = 16'h0300;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("mid_grant", i_grant, 1);
            chk("mid_addr", mem_addr, 16'h0300 + 16'(2 * c));
            tick();
        end
        rst_n = 1'b0; i_req = 1'b0;
        tick();
        chk_quiet("mid_reset");
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("stray_vld", {i_data_vld, d_data_vld}, 0);
            chk("stray_done", {i_done, d_done}, 0);
            chk("stray_data", fill_data, 0);
            tick();
        end

        // Requester drops i_req early; the fill still completes.
        i_req = 1'b1; i_addr = 16'h0500;
        tick();
        run_fill(1'b0, 16'h0500, 2, 1'b0);
        chk_quiet("drop_gap");
        tick();
        chk_quiet("drop_no_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
